// File: rtl/alu_pair_pkg.sv
// Shared types and constants for the dual-lane ALU stimulus driver and its LFSR.
package alu_pair_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int unsigned       LFSR_W       = 20;
    localparam int unsigned       LFSR_TAP_HI  = 19;  // x^20
    localparam int unsigned       LFSR_TAP_LO  = 16;  // x^17
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 20'h5A5A5;

    // Stimulus word layout, MSB first: a0, b0, a1, b1, sel1, sel2
    localparam int unsigned A0_LSB   = 16;
    localparam int unsigned B0_LSB   = 12;
    localparam int unsigned A1_LSB   = 8;
    localparam int unsigned B1_LSB   = 4;
    localparam int unsigned SEL1_LSB = 2;
    localparam int unsigned SEL2_LSB = 0;

    typedef struct packed {
        logic [3:0] a0;
        logic [3:0] b0;
        logic [3:0] a1;
        logic [3:0] b1;
        logic [1:0] sel1;
        logic [1:0] sel2;
    } stim_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/alu_pair_lfsr.sv
// 20-bit Fibonacci LFSR (x^20+x^17+1) with synchronous reload to the seed.
module alu_pair_lfsr
    import alu_pair_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_en,
    output logic [LFSR_W-1:0] o_state
);

    // An all-zero seed would lock the register up
    localparam logic [LFSR_W-1:0] SEED_EFF =
        (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;

    logic [LFSR_W-1:0] r_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SEED_EFF;
        end else if (i_load) begin
            r_state <= SEED_EFF;
        end else if (i_en) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/alu_pair_driver.sv
// Drives both ALU lanes from an LFSR, checks lockstep responses and counts mismatches.
module alu_pair_driver
    import alu_pair_pkg::*;
#(
    parameter int unsigned       RESP_LAT = 1,
    parameter logic [LFSR_W-1:0] SEED     = DEFAULT_SEED,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_vectors_i,
    input  logic             inject_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [CNT_W-1:0] vec_count_o,
    output logic [3:0]       a0_o,
    output logic [3:0]       b0_o,
    output logic [3:0]       a1_o,
    output logic [3:0]       b1_o,
    output logic [1:0]       sel1_o,
    output logic [1:0]       sel2_o,
    input  logic [3:0]       alu_out1_i,
    input  logic [3:0]       alu_out2_i,
    input  logic             carry1_i,
    input  logic             carry2_i,
    input  logic [3:0]       x_i,
    input  logic             y_i
);

    state_t            r_state;
    logic [CNT_W-1:0]  r_num;
    logic [CNT_W-1:0]  r_vec;
    logic [CNT_W-1:0]  r_err;
    logic              r_inject;
    logic              r_done;
    logic              r_pass;
    logic [1:0]        r_drain;
    stim_t             r_stim;
    // Stage 0 tracks our own output register; RESP_LAT further stages cover the macro
    logic [RESP_LAT:0] r_vld;

    logic [LFSR_W-1:0] w_lfsr;
    stim_t             w_stim;
    logic              w_accept;
    logic              w_run;
    logic              w_mismatch;
    logic              w_err_inc;
    logic [CNT_W-1:0]  w_err_next;
    logic [CNT_W-1:0]  w_vec_next;

    assign w_accept = (r_state == ST_IDLE) && start_i;
    assign w_run    = (r_state == ST_RUN);

    alu_pair_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .i_clk  (wb_clk_i),
        .i_rst_n(wb_rst_ni),
        .i_load (w_accept),
        .i_en   (w_run),
        .o_state(w_lfsr)
    );

    always_comb begin
        w_stim      = stim_t'(w_lfsr);
        w_stim.a1   = w_stim.a0;
        w_stim.b1   = w_stim.b0 ^ {3'b000, r_inject};
        w_stim.sel2 = w_stim.sel1 ^ {1'b0, r_inject};
    end

    assign w_mismatch = (alu_out1_i != alu_out2_i) | (carry1_i != carry2_i) |
                        (x_i != '0) | y_i;
    assign w_err_inc  = r_vld[RESP_LAT] && w_mismatch && (r_err != '1);
    assign w_err_next = r_err + CNT_W'(w_err_inc);
    assign w_vec_next = r_vec + 1'b1;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state  <= ST_IDLE;
            r_num    <= '0;
            r_vec    <= '0;
            r_err    <= '0;
            r_inject <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_drain  <= '0;
            r_stim   <= '0;
            r_vld    <= '0;
        end else begin
            r_done <= 1'b0;
            r_vld  <= {r_vld[RESP_LAT-1:0], 1'b0};
            r_err  <= w_err_next;
            unique case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_num    <= num_vectors_i;
                        r_inject <= inject_i;
                        r_vec    <= '0;
                        r_err    <= '0;
                        r_state  <= (num_vectors_i == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_stim   <= w_stim;
                    r_vld[0] <= 1'b1;
                    r_vec    <= w_vec_next;
                    r_drain  <= '0;
                    if (w_vec_next == r_num) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == 2'(RESP_LAT - 1)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                ST_DONE: begin
                    // The final response is checked on this same edge, so use the updated count
                    r_done  <= 1'b1;
                    r_pass  <= (r_num == '0) ? 1'b1 :
                               (r_inject ? (w_err_next != '0) : (w_err_next == '0));
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o      = (r_state != ST_IDLE);
    assign done_o      = r_done;
    assign pass_o      = r_pass;
    assign err_count_o = r_err;
    assign vec_count_o = r_vec;
    assign a0_o        = r_stim.a0;
    assign b0_o        = r_stim.b0;
    assign a1_o        = r_stim.a1;
    assign b1_o        = r_stim.b1;
    assign sel1_o      = r_stim.sel1;
    assign sel2_o      = r_stim.sel2;

endmodule

// File: tb/tb_alu_pair_driver.sv
// Scoreboard bench for alu_pair_driver with a registered dual-lane ALU loopback model.
module tb_alu_pair_driver;

    localparam int unsigned RESP_LAT = 1;
    localparam int unsigned CNT_W    = 16;
    localparam logic [19:0] SEED_V   = 20'h5A5A5;

    logic             clk = 1'b0;
    logic             wb_rst_ni;
    logic             start_i;
    logic [CNT_W-1:0] num_vectors_i;
    logic             inject_i;
    logic             busy_o, done_o, pass_o;
    logic [CNT_W-1:0] err_count_o, vec_count_o;
    logic [3:0]       a0_o, b0_o, a1_o, b1_o;
    logic [1:0]       sel1_o, sel2_o;
    logic [3:0]       alu_out1_i, alu_out2_i, x_i;
    logic             carry1_i, carry2_i, y_i;

    alu_pair_driver #(
        .RESP_LAT(RESP_LAT),
        .SEED    (SEED_V),
        .CNT_W   (CNT_W)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (wb_rst_ni),
        .start_i      (start_i),
        .num_vectors_i(num_vectors_i),
        .inject_i     (inject_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .pass_o       (pass_o),
        .err_count_o  (err_count_o),
        .vec_count_o  (vec_count_o),
        .a0_o         (a0_o),
        .b0_o         (b0_o),
        .a1_o         (a1_o),
        .b1_o         (b1_o),
        .sel1_o       (sel1_o),
        .sel2_o       (sel2_o),
        .alu_out1_i   (alu_out1_i),
        .alu_out2_i   (alu_out2_i),
        .carry1_i     (carry1_i),
        .carry2_i     (carry2_i),
        .x_i          (x_i),
        .y_i          (y_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned idx;
        logic [19:0] word;
    } stim_exp_t;

    typedef struct {
        int unsigned err;
        bit          pass;
        int unsigned vec;
    } res_exp_t;

    stim_exp_t   exp_stim[$];
    res_exp_t    exp_res[$];
    int unsigned n_vec = 0;
    int unsigned n_mis = 0;
    logic [19:0] seq[128];
    logic [19:0] last_word = '0;
    bit          tb_new_vec = 1'b0;
    bit          frc_on = 1'b0;
    int unsigned frc_idx[3];

    function automatic logic [4:0] alu(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] s);
        case (s)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    function automatic logic [19:0] lanes(input logic [19:0] raw, input bit inj);
        logic [3:0] a, b;
        logic [1:0] s;
        a = raw[19:16];
        b = raw[15:12];
        s = raw[3:2];
        return {a, b, a, b ^ {3'b000, inj}, s, s ^ {1'b0, inj}};
    endfunction

    // Loopback macro: both lanes registered once, compare flags derived from the lane outputs
    logic [3:0]  m_out1 = '0, m_out2 = '0;
    logic        m_c1 = 1'b0, m_c2 = 1'b0, m_vld = 1'b0;
    int unsigned m_k = 0;

    always @(posedge clk) begin
        {m_c1, m_out1} <= alu(a0_o, b0_o, sel1_o);
        {m_c2, m_out2} <= alu(a1_o, b1_o, sel2_o);
        m_vld          <= tb_new_vec;
        m_k            <= vec_count_o;
    end

    assign alu_out1_i = m_out1;
    assign alu_out2_i = m_out2;
    assign carry1_i   = m_c1;
    assign carry2_i   = m_c2;
    assign x_i        = m_out1 ^ m_out2;
    assign y_i        = (m_c1 ^ m_c2) |
                        (frc_on && m_vld &&
                         (m_k == frc_idx[0] || m_k == frc_idx[1] || m_k == frc_idx[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] stim_word();
        return {a0_o, b0_o, a1_o, b1_o, sel1_o, sel2_o};
    endfunction

    // Monitor: a new vector is presented whenever vec_count_o steps while busy
    initial begin : monitor
        logic [CNT_W-1:0] prev;
        stim_exp_t        es;
        res_exp_t         er;
        prev = '0;
        forever begin
            @(negedge clk);
            tb_new_vec = 1'b0;
            if (busy_o === 1'b1 && vec_count_o !== prev && vec_count_o !== '0) begin
                tb_new_vec = 1'b1;
                if (exp_stim.size() == 0) begin
                    chk("unexpected_vector", vec_count_o, 0);
                end else begin
                    es = exp_stim.pop_front();
                    chk("stim_word", stim_word(), es.word);
                    chk("vec_index", vec_count_o, es.idx);
                end
            end
            prev = vec_count_o;
            if (done_o === 1'b1) begin
                if (exp_res.size() == 0) begin
                    chk("unexpected_done", {31'b0, done_o}, 0);
                end else begin
                    er = exp_res.pop_front();
                    chk("err_count", err_count_o, er.err);
                    chk("pass", {31'b0, pass_o}, {31'b0, er.pass});
                    chk("vec_count", vec_count_o, er.vec);
                end
            end
        end
    end

    task automatic zero_chk(input string tag);
        chk({tag, "_busy"}, {31'b0, busy_o}, 0);
        chk({tag, "_done"}, {31'b0, done_o}, 0);
        chk({tag, "_pass"}, {31'b0, pass_o}, 0);
        chk({tag, "_err"}, err_count_o, 0);
        chk({tag, "_vec"}, vec_count_o, 0);
        chk({tag, "_stim"}, stim_word(), 0);
    endtask

    task automatic push_stim(input int unsigned n, input bit inj, input bit frc,
                             output int unsigned err);
        logic [19:0] w;
        err = 0;
        for (int unsigned k = 1; k <= n; k++) begin
            w = lanes(seq[k-1], inj);
            exp_stim.push_back('{idx: k, word: w});
            if (alu(w[19:16], w[15:12], w[3:2]) != alu(w[11:8], w[7:4], w[1:0]) ||
                (frc && (k == frc_idx[0] || k == frc_idx[1] || k == frc_idx[2])))
                err++;
            last_word = w;
        end
    endtask

    task automatic issue_start(input int unsigned n, input bit inj);
        @(negedge clk);
        num_vectors_i = CNT_W'(n);
        inject_i      = inj;
        start_i       = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic run(input int unsigned n, input bit inj, input bit frc, input bit restart);
        int unsigned err;
        int unsigned cyc;
        bit          pass;
        frc_idx[0] = 3;
        frc_idx[1] = 7;
        frc_idx[2] = n;
        push_stim(n, inj, frc, err);
        pass = (n == 0) ? 1'b1 : (inj ? (err != 0) : (err == 0));
        exp_res.push_back('{err: err, pass: pass, vec: n});
        frc_on = frc;
        issue_start(n, inj);
        cyc = 0;
        while (done_o !== 1'b1 && cyc < n + RESP_LAT + 20) begin
            @(negedge clk);
            cyc++;
            start_i = restart && (cyc == n / 2);
        end
        start_i = 1'b0;
        chk("done_latency", cyc, (n == 0) ? 1 : n + RESP_LAT + 1);
        if (done_o !== 1'b1) begin
            exp_stim.delete();
            exp_res.delete();
        end
        chk("busy_at_done", {31'b0, busy_o}, 0);
        @(negedge clk);
        frc_on = 1'b0;
        chk("done_one_cycle", {31'b0, done_o}, 0);
        chk("stim_hold", stim_word(), last_word);
    endtask

    task automatic reset_mid(input int unsigned n, input int unsigned at);
        int unsigned err;
        int unsigned cyc;
        push_stim(n, 1'b0, 1'b0, err);
        issue_start(n, 1'b0);
        cyc = 0;
        while (vec_count_o !== CNT_W'(at) && cyc < n + 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_point", vec_count_o, at);
        #2 wb_rst_ni = 1'b0;
        #1 zero_chk("async_reset");
        exp_stim.delete();
        last_word = '0;
        repeat (3) @(negedge clk);
        wb_rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        zero_chk("after_abort");
    endtask

    initial begin : driver
        bit bits[$];
        logic [19:0] sd;
        wb_rst_ni     = 1'b0;
        start_i       = 1'b0;
        num_vectors_i = '0;
        inject_i      = 1'b0;

        // Reference stimulus stream: b[n] = b[n-20] ^ b[n-17], word k = bits k..k+19
        sd = SEED_V;
        for (int i = 0; i < 20; i++) bits.push_back(sd[19-i]);
        for (int k = 0; k < 128; k++) begin
            for (int i = 0; i < 20; i++) seq[k][19-i] = bits[k+i];
            bits.push_back(bits[k] ^ bits[k+3]);
        end

        repeat (2) @(negedge clk);
        zero_chk("in_reset");
        wb_rst_ni = 1'b1;
        repeat (3) @(negedge clk);
        zero_chk("idle_no_start");

        run(100, 1'b0, 1'b0, 1'b0);
        run(100, 1'b1, 1'b0, 1'b0);
        run(20,  1'b0, 1'b1, 1'b0);
        run(0,   1'b0, 1'b0, 1'b0);
        run(0,   1'b1, 1'b0, 1'b0);
        run(50,  1'b0, 1'b0, 1'b1);
        repeat (4) run($urandom_range(1, 40), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        reset_mid(40, 10);
        run(40, 1'b0, 1'b0, 1'b0);

        chk("stim_queue_empty", exp_stim.size(), 0);
        chk("res_queue_empty", exp_res.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
